// File: rtl/morse_player.sv
// Real-time Morse playback: plays up to five latched elements on `tone` with
// standard unit timing and signals completion with a busy/done handshake.
module morse_player #(
    parameter int UNIT_CYCLES = 12500000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [4:0] morse,
    input  logic [4:0] mask,
    output logic       busy,
    output logic       done,
    output logic       tone,
    output logic       ponto,
    output logic       traco,
    output logic [2:0] elem_idx
);

    localparam int CW = $clog2(3 * UNIT_CYCLES + 1);
    // Counter is loaded with duration-1 so a state lasts exactly the loaded span.
    localparam logic [CW-1:0] C_UNIT = CW'(UNIT_CYCLES - 1);
    localparam logic [CW-1:0] C_TRIPLE = CW'(3 * UNIT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_MARK,
        S_SPACE,
        S_END_GAP,
        S_FINISH
    } state_t;

    state_t          r_state;
    state_t          w_state_nx;
    logic [CW-1:0]   r_cnt;
    logic [CW-1:0]   w_cnt_nx;
    logic [2:0]      r_idx;
    logic [2:0]      w_idx_nx;
    logic [2:0]      w_idx_dn;
    logic [4:0]      r_morse;
    logic [4:0]      r_mask;
    logic            w_latch;
    logic            w_dot_nx;
    logic            w_cnt_zero;
    logic            w_below_ok;
    logic            r_busy;
    logic            r_done;
    logic            r_tone;
    logic            r_ponto;
    logic            r_traco;

    assign w_idx_dn   = r_idx - 3'd1;
    assign w_cnt_zero = (r_cnt == '0);
    assign w_below_ok = (r_idx != 3'd0) && r_mask[w_idx_dn];

    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        w_idx_nx   = r_idx;
        w_latch    = 1'b0;
        w_dot_nx   = r_morse[r_idx];
        case (r_state)
            S_IDLE: begin
                w_idx_nx = 3'd0;
                if (start) begin
                    w_latch = 1'b1;
                    if (mask[4]) begin
                        w_state_nx = S_MARK;
                        w_idx_nx   = 3'd4;
                        w_dot_nx   = morse[4];
                        w_cnt_nx   = morse[4] ? C_UNIT : C_TRIPLE;
                    end else begin
                        w_state_nx = S_FINISH;
                    end
                end
            end
            S_MARK: begin
                if (w_cnt_zero) begin
                    if (w_below_ok) begin
                        w_state_nx = S_SPACE;
                        w_cnt_nx   = C_UNIT;
                    end else begin
                        w_state_nx = S_END_GAP;
                        w_cnt_nx   = C_TRIPLE;
                    end
                end else begin
                    w_cnt_nx = r_cnt - CW'(1);
                end
            end
            S_SPACE: begin
                if (w_cnt_zero) begin
                    w_state_nx = S_MARK;
                    w_idx_nx   = w_idx_dn;
                    w_dot_nx   = r_morse[w_idx_dn];
                    w_cnt_nx   = r_morse[w_idx_dn] ? C_UNIT : C_TRIPLE;
                end else begin
                    w_cnt_nx = r_cnt - CW'(1);
                end
            end
            S_END_GAP: begin
                if (w_cnt_zero) begin
                    w_state_nx = S_FINISH;
                    w_idx_nx   = 3'd0;
                end else begin
                    w_cnt_nx = r_cnt - CW'(1);
                end
            end
            S_FINISH: begin
                w_state_nx = S_IDLE;
                w_idx_nx   = 3'd0;
            end
            default: begin
                w_state_nx = S_IDLE;
                w_idx_nx   = 3'd0;
            end
        endcase
    end

    // Outputs are registered from the next-state decode so they line up with the state.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_idx   <= 3'd0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_tone  <= 1'b0;
            r_ponto <= 1'b0;
            r_traco <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
            r_idx   <= w_idx_nx;
            r_busy  <= (w_state_nx == S_MARK) || (w_state_nx == S_SPACE) ||
                       (w_state_nx == S_END_GAP);
            r_done  <= (w_state_nx == S_FINISH);
            r_tone  <= (w_state_nx == S_MARK);
            r_ponto <= (w_state_nx == S_MARK) && w_dot_nx;
            r_traco <= (w_state_nx == S_MARK) && !w_dot_nx;
        end
    end

    always_ff @(posedge clk) begin
        if (w_latch) begin
            r_morse <= morse;
            r_mask  <= mask;
        end
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign tone     = r_tone;
    assign ponto    = r_ponto;
    assign traco    = r_traco;
    assign elem_idx = r_idx;

endmodule

// File: tb/tb_morse_player.sv
// Bench for morse_player (UNIT_CYCLES=2): a timeline model built from Morse
// timing rules, checked against the DUT outputs every cycle.
module tb_morse_player;

    localparam int U    = 2;
    localparam int MAXC = 1024;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [4:0] morse;
    logic [4:0] mask;
    logic       busy, done, tone, ponto, traco;
    logic [2:0] elem_idx;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    bit chk_en   = 1'b0;

    bit       exp_busy  [MAXC];
    bit       exp_done  [MAXC];
    bit       exp_tone  [MAXC];
    bit       exp_ponto [MAXC];
    bit       exp_traco [MAXC];
    bit [2:0] exp_idx   [MAXC];
    bit       exp_idxdc [MAXC];

    morse_player #(.UNIT_CYCLES(U)) dut (
        .clk(clk), .reset(reset), .start(start), .morse(morse), .mask(mask),
        .busy(busy), .done(done), .tone(tone), .ponto(ponto), .traco(traco),
        .elem_idx(elem_idx)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp_v, input int c);
        checks++;
        if (act !== exp_v) begin
            failures++;
            $display("FAIL %s cycle=%0d actual=%0d expected=%0d", name, c, act, exp_v);
        end
    endtask

    // Per-cycle comparison of every output against the model timeline.
    always @(negedge clk) begin
        if (chk_en && cyc < MAXC) begin
            chk("busy",  int'(busy),  int'(exp_busy[cyc]),  cyc);
            chk("done",  int'(done),  int'(exp_done[cyc]),  cyc);
            chk("tone",  int'(tone),  int'(exp_tone[cyc]),  cyc);
            chk("ponto", int'(ponto), int'(exp_ponto[cyc]), cyc);
            chk("traco", int'(traco), int'(exp_traco[cyc]), cyc);
            if (!exp_idxdc[cyc])
                chk("elem_idx", int'(elem_idx), int'(exp_idx[cyc]), cyc);
        end
    end

    // Model: list elements from bit 4 down to the first cleared mask bit, then
    // lay out mark / inter-element space / final 3-unit gap / done.
    task automatic plan(input int s, input logic [4:0] m, input logic [4:0] k, output int dc);
        int pol[5];
        int n;
        int t;
        int d;
        n = 0;
        for (int i = 4; i >= 0; i--) begin
            if (!k[i]) break;
            pol[n] = int'(m[i]);
            n++;
        end
        t = s + 1;
        for (int e = 0; e < n; e++) begin
            d = (pol[e] != 0) ? U : 3 * U;
            for (int j = 0; j < d; j++) begin
                exp_tone[t]  = 1'b1;
                exp_ponto[t] = (pol[e] != 0);
                exp_traco[t] = (pol[e] == 0);
                exp_busy[t]  = 1'b1;
                exp_idx[t]   = 3'(4 - e);
                t++;
            end
            if (e < n - 1) begin
                for (int j = 0; j < U; j++) begin
                    exp_busy[t] = 1'b1;
                    exp_idx[t]  = 3'(4 - e);
                    t++;
                end
            end
        end
        if (n > 0) begin
            for (int j = 0; j < 3 * U; j++) begin
                exp_busy[t] = 1'b1;
                exp_idx[t]  = 3'(4 - (n - 1));
                t++;
            end
        end
        exp_done[t]  = 1'b1;
        exp_idxdc[t] = 1'b1;
        dc = t;
    endtask

    task automatic cancel(input int from_c, input int to_c);
        for (int c = from_c; c <= to_c; c++) begin
            exp_busy[c] = 1'b0; exp_done[c] = 1'b0; exp_tone[c] = 1'b0;
            exp_ponto[c] = 1'b0; exp_traco[c] = 1'b0; exp_idx[c] = 3'd0;
            exp_idxdc[c] = 1'b0;
        end
    endtask

    // Start is held for one cycle; the inputs then change to prove they were latched.
    task automatic pulse_start(input logic [4:0] m, input logic [4:0] k);
        start = 1'b1; morse = m; mask = k;
        @(negedge clk);
        start = 1'b0; morse = ~m; mask = ~k;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic play(input string name, input logic [4:0] m, input logic [4:0] k,
                        input int rel_done);
        int s;
        int dc;
        s = cyc;
        plan(s, m, k, dc);
        chk({name, "_model_done"}, dc - s, rel_done, s);
        pulse_start(m, k);
        wait_until(dc + 3);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog cycle=%0d actual=timeout expected=finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int s;
        int dc;
        int tones;
        reset = 1'b1; start = 1'b0; morse = 5'd0; mask = 5'd0;
        @(negedge clk);
        chk_en = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        play("E", 5'b10000, 5'b10000, 9);
        play("A", 5'b10000, 5'b11000, 17);

        s = cyc;
        plan(s, 5'b00000, 5'b11111, dc);
        chk("zero_model_done", dc - s, 45, s);
        tones = 0;
        for (int c = s + 1; c <= dc; c++) tones += int'(exp_tone[c]);
        chk("zero_model_tone_cycles", tones, 30, s);
        pulse_start(5'b00000, 5'b11111);
        wait_until(dc + 3);

        play("empty", 5'b10101, 5'b00000, 1);
        play("noncontig", 5'b10100, 5'b10100, 9);

        // Start during playback is ignored; the cycle after done is accepted.
        s = cyc;
        plan(s, 5'b00000, 5'b10000, dc);
        chk("T_model_done", dc - s, 13, s);
        pulse_start(5'b00000, 5'b10000);
        wait_until(s + 4);
        pulse_start(5'b11111, 5'b11111);
        wait_until(s + 14);
        play("T_restart", 5'b10000, 5'b11000, 17);

        // Reset mid-playback drops the character; a later start plays normally.
        s = cyc;
        plan(s, 5'b00000, 5'b10000, dc);
        pulse_start(5'b00000, 5'b10000);
        wait_until(s + 3);
        reset = 1'b1;
        cancel(s + 4, dc + 1);
        @(negedge clk);
        reset = 1'b0;
        wait_until(s + 5);
        play("after_reset", 5'b10000, 5'b10000, 9);

        // Reset and start together: reset wins, nothing plays.
        reset = 1'b1; start = 1'b1; morse = 5'b11111; mask = 5'b11111;
        @(negedge clk);
        reset = 1'b0; start = 1'b0; mask = 5'b00000;
        repeat (6) @(negedge clk);

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/morse_player.md
# morse_player

Sequential Morse playback stage. It consumes the `morse[4:0]` / `display[4:0]` pair produced by the Morse encoder and plays the character out in real time on a single `tone` line, using standard Morse timing. It also drives `ponto` / `traco` element indicators for the seven-segment/LED stage. It sits between the encoder and the board outputs (buzzer/LED), and reports completion with a `busy`/`done` handshake to the character-entry control.

## Interface

Parameters:
- `UNIT_CYCLES`, default 12500000: clock cycles per Morse time unit (250 ms at 50 MHz); legal range ≥ 1.

Ports:
- `clk`  input  1  system clock; all logic is on its rising edge.
- `reset`  input  1  synchronous, active-high reset.
- `start`  input  1  request to play the character on `morse`/`mask`; accepted only when `busy`=0.
- `morse`  input  5  element polarity, one bit per element: 1 = dot, 0 = dash. Bit 4 is the first element.
- `mask`  input  5  element valid flags (the encoder's `display` output); 1 = element present.
- `busy`  output  1  high while a character is being played.
- `done`  output  1  one-cycle pulse when playback ends.
- `tone`  output  1  Morse keying output; 1 = mark (sounding).
- `ponto`  output  1  high while the current mark is a dot.
- `traco`  output  1  high while the current mark is a dash.
- `elem_idx`  output  3  index (4..0) of the element being played; 0 when idle.

## Operation

- State machine: IDLE, MARK, SPACE, END_GAP, FINISH.
- **IDLE:** when `start`=1, latch `morse` and `mask` into shadow registers. Later input changes have no effect until the next accepted start.
  - If `mask[4]`=1, go to MARK with `elem_idx`=4.
  - If `mask[4]`=0, go to FINISH. Nothing is played and `busy` never rises.
- **Element list:** the character is bit 4 downward, stopping at the first cleared mask bit. Set bits below a cleared bit are ignored.
- **MARK:** `tone`=1 for D cycles.
  - D = `UNIT_CYCLES` for a dot, 3×`UNIT_CYCLES` for a dash.
  - `ponto`/`traco` are set per the latched polarity; exactly one is high in MARK.
- **After MARK:**
  - If the element below is valid (`elem_idx`>0 and its mask bit is 1), go to SPACE for `UNIT_CYCLES` cycles, then MARK with `elem_idx` decremented.
  - Otherwise go to END_GAP for 3×`UNIT_CYCLES` cycles, then FINISH.
- **FINISH:** lasts one cycle. `done`=1, `busy`=0, then return to IDLE.
- **Accepting a new start:** `start` is ignored while `busy`=1. It is accepted in IDLE only; FINISH does not accept it.
- **Duration counter:** one down-counter of width ceil(log2(3×`UNIT_CYCLES`+1)). It is loaded on each state entry and advances the state when it reaches its terminal count. It has no wrap-around.
- **Reset:** in any state, takes effect on the next edge. The FSM returns to IDLE and every output goes to 0; an in-progress character is dropped.

## Timing

- **Reset values:** `busy`=0, `done`=0, `tone`=0, `ponto`=0, `traco`=0, `elem_idx`=0.
- **Latency:** all outputs are registered. If `start` is sampled at edge 0:
  - `busy`, `tone` and the first element's `ponto`/`traco` are high from cycle 1.
  - `done` appears at cycle 1 when `mask[4]`=0.
- **Durations:**
  - `tone` high for exactly D cycles per element.
  - Low for exactly `UNIT_CYCLES` between elements.
  - Low for exactly 3×`UNIT_CYCLES` after the last element before `done`.
- **Handshake cycle:** `busy` falls in the same cycle `done` pulses. IDLE follows, so the earliest accepted restart is `start` high one cycle after `done`.
- **Outside MARK:** `ponto`=`traco`=0. `elem_idx` holds its value through SPACE and END_GAP.
- **Simultaneous `reset` and `start`:** reset wins and `start` is ignored.

## Test plan

All scenarios use `UNIT_CYCLES`=2 with `start` pulsed at cycle 0.

- **'E'** (`morse`=10000, `mask`=10000) -> `tone`/`ponto` high cycles 1–2; low 3–8; `done` at cycle 9; `busy` high 1–8.
- **'A'** (`morse`=10000, `mask`=11000) -> `tone` 1–2 with `ponto`; low 3–4; `tone` 5–10 with `traco` and `elem_idx`=3; low 11–16; `done` at 17.
- **'0'** (`morse`=00000, `mask`=11111) -> five 6-cycle marks separated by 2-cycle spaces covering cycles 1–38; low 39–44; `done` at 45.
- **Empty and non-contiguous masks:**
  - `mask`=00000 -> `done` at cycle 1; `tone` and `busy` never high.
  - `mask`=10100, `morse`=10100 -> only a dot plays (`tone` 1–2); `done` at 9.
- **`start` while busy:** during 'T' (`mask`=10000, `morse`=00000), pulse `start` with new data at cycle 4 -> ignored; `tone` 1–6; `done` at 13. A `start` at cycle 14 is accepted and `busy` rises at 15.
- **Reset mid-playback:** assert `reset` at cycle 3 during 'T' -> all outputs 0 at cycle 4; no `done`; a new `start` at cycle 5 plays normally.
